// File: rtl/rv_pkg.sv
// Shared pipeline types and constants for the single-issue RISC-V core.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection and fetch address checker.
module pc_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        bad
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q;
    logic [31:0] pc_n;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign bad      = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);

    always_comb begin
        pc_n = pc_q;
        if (!hold) begin
            pc_n = redirect ? target : pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_n;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, IF/ID capture, stall/redirect handling
// and a sticky fault on misaligned or out-of-range fetch addresses.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect_e,
    input  logic [31:0] redirect_target_e,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault
);

    fetch_state_t state, state_n;
    if_id_t       if_id, if_id_n;
    logic [31:0]  pc_f, pc_f_plus4;
    logic         pc_bad;
    logic         pc_hold;

    // PC moves only in RUN, on a good address, when not stalled (redirect beats stall).
    assign pc_hold = (state != RUN) || pc_bad || (stall_d && !redirect_e);

    pc_reg #(
        .RESET_PC  (RESET_PC),
        .IMEM_BYTES(IMEM_BYTES)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .hold    (pc_hold),
        .redirect(redirect_e),
        .target  (redirect_target_e),
        .pc      (pc_f),
        .pc_plus4(pc_f_plus4),
        .bad     (pc_bad)
    );

    assign imem_addr = pc_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if_id_n = if_id;
        case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (pc_bad) begin
                    state_n       = FAULT;
                    if_id_n.valid = 1'b0;
                    if_id_n.instr = NOP_INSTR;
                end else if (redirect_e) begin
                    if_id_n.valid = 1'b0;
                    if_id_n.instr = NOP_INSTR;
                end else if (!stall_d) begin
                    if_id_n = '{valid: 1'b1, instr: imem_rdata, pc: pc_f, pc_plus4: pc_f_plus4};
                end
            end
            FAULT: state_n = FAULT;
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0};
        end else begin
            if_id <= if_id_n;
        end
    end

    assign if_id_valid    = if_id.valid;
    assign if_id_instr    = if_id.instr;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign fetch_fault    = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] redirect_target_e;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [32];

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'h0;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .stall_d          (stall_d),
        .redirect_e       (redirect_e),
        .redirect_target_e(redirect_target_e),
        .if_id_valid      (if_id_valid),
        .if_id_instr      (if_id_instr),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .fetch_fault      (fetch_fault)
    );

    // Reference model state: where fetch points and what decode should see.
    logic [31:0] m_pc;
    logic        m_boot, m_fault, m_fresh;
    logic        m_valid;
    logic [31:0] m_instr, m_ipc, m_ip4;
    logic [31:0] last_valid_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic stl, input logic rd, input logic [31:0] tgt);
        m_fresh = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_boot = 1'b1; m_fault = 1'b0; m_fresh = 1'b1;
            m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0; m_ip4 = 32'h0;
        end else if (m_fault) begin
            // frozen until reset
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pc % 4 != 0 || m_pc > 32'd124) begin
            m_fault = 1'b1; m_valid = 1'b0; m_instr = NOP;
        end else if (rd) begin
            m_pc = tgt; m_valid = 1'b0; m_instr = NOP;
        end else if (!stl) begin
            m_valid = 1'b1; m_instr = mem[m_pc / 4]; m_ipc = m_pc; m_ip4 = m_pc + 4;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic cyc(input logic rst, input logic stl, input logic rd, input logic [31:0] tgt);
        reset = rst; stall_d = stl; redirect_e = rd; redirect_target_e = tgt;
        @(posedge clk);
        model_edge(rst, stl, rd, tgt);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("instr", if_id_instr, m_instr);
        chk("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        if (m_valid || m_fresh) begin
            chk("if_id_pc", if_id_pc, m_ipc);
            chk("if_id_pc4", if_id_pc_plus4, m_ip4);
        end
        if (if_id_valid) last_valid_pc = if_id_pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0]  = 32'h0050_0113;
        mem[1]  = 32'h00c0_0193;
        mem[2]  = 32'hff71_8393;
        mem[16] = 32'h0080_01ef;
        m_pc = 0; m_boot = 1; m_fault = 0; m_fresh = 0;
        m_valid = 0; m_instr = NOP; m_ipc = 0; m_ip4 = 0;
        last_valid_pc = 0;
        reset = 1; stall_d = 0; redirect_e = 0; redirect_target_e = 0;
        #1;

        // Reset, boot, first two fetches
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("boot_invalid", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("first_instr", if_id_instr, 32'h0050_0113);
        cyc(0, 0, 0, 0);
        chk("second_instr", if_id_instr, 32'h00c0_0193);

        // Three-cycle stall at pc_f=0x8
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_pc", if_id_pc, 32'h4);
        end
        cyc(0, 0, 0, 0);
        chk("post_stall", if_id_instr, 32'hff71_8393);

        // Redirect wins over a simultaneous stall
        cyc(0, 1, 1, 32'h40);
        chk("redir_addr", imem_addr, 32'h40);
        cyc(0, 0, 0, 0);
        chk("redir_instr", if_id_instr, 32'h0080_01ef);
        chk("redir_pc", if_id_pc, 32'h40);

        // Misaligned redirect: sticky fault ignores later redirects
        cyc(0, 0, 1, 32'h22);
        cyc(0, 0, 0, 0);
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 10; i++) cyc(0, i[0], 1, 32'h0);
        chk("frozen_addr", imem_addr, 32'h22);
        cyc(1, 0, 0, 0);
        chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);

        // Sequential run off the end of memory
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h70);
        for (int i = 0; i < 20 && !fetch_fault; i++) cyc(0, 0, 0, 0);
        chk("range_fault", {31'd0, fetch_fault}, 32'd1);
        chk("range_addr", imem_addr, 32'h80);
        chk("last_valid_pc", last_valid_pc, 32'h7c);

        // Reset in the middle of a stall at pc_f=0x30
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h30);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("rst_stall_addr", imem_addr, 32'h0);
        chk("rst_stall_pc", if_id_pc, 32'h0);

        // Random traffic, occasional bad targets and resets
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_stl, r_rd;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 3);
            r_stl = ($urandom_range(0, 99) < 25);
            r_rd  = ($urandom_range(0, 99) < 10);
            r_tgt = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            if ($urandom_range(0, 99) < 5) r_tgt = r_tgt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 99) < 3) r_tgt = 32'h100;
            cyc(r_rst, r_stl, r_rd, r_tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
